// File: rtl/ihex_pkg.sv
// Shared Intel HEX record-type constants and parser state encoding.
package ihex_pkg;

    localparam logic [7:0] REC_DATA = 8'h00;
    localparam logic [7:0] REC_EOF  = 8'h01;
    localparam logic [7:0] REC_ESA  = 8'h02;
    localparam logic [7:0] REC_ELA  = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_ADDR,
        ST_TYPE,
        ST_DATA,
        ST_CSUM
    } ihex_state_t;

endpackage

// File: rtl/ihex_digit.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f map to a nibble with a valid flag.
module ihex_digit (
    input  logic [7:0] i_char,
    output logic [3:0] o_nib,
    output logic       o_valid
);

    always_comb begin
        o_nib   = 4'h0;
        o_valid = 1'b0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_nib   = i_char[3:0];
            o_valid = 1'b1;
        end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                     (i_char >= 8'h61 && i_char <= 8'h66)) begin
            o_nib   = i_char[3:0] + 4'd9;
            o_valid = 1'b1;
        end
    end

endmodule

// File: rtl/ihex_loader.sv
// Streaming Intel HEX parser: turns ioctl ASCII download characters into byte writes
// with checksum, character and address-range error reporting.
module ihex_loader
    import ihex_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter bit EXT_ADDR   = 1'b1,
    parameter bit CHECK_CSUM = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              done,
    output logic              err_csum,
    output logic              err_char,
    output logic              err_range,
    output logic [15:0]       rec_cnt
);

    ihex_state_t       r_state;
    ihex_state_t       w_state_n;
    logic              r_nib;
    logic [3:0]        r_hi;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [15:0]       r_ofs;
    logic [7:0]        r_type;
    logic [7:0]        r_sum;
    logic [31:0]       r_base;
    logic [15:0]       r_ext;
    logic              r_dl_prev;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_data;
    logic              r_done;
    logic              r_err_csum;
    logic              r_err_char;
    logic              r_err_range;
    logic [15:0]       r_rec_cnt;

    logic [3:0]  w_nib;
    logic        w_hex;
    logic        w_take;
    logic        w_colon;
    logic        w_dl;
    logic        w_start;
    logic [7:0]  w_byte;
    logic [7:0]  w_sum;
    logic [31:0] w_ea;
    logic        w_last;

    ihex_digit u_digit (
        .i_char  (ioctl_dout),
        .o_nib   (w_nib),
        .o_valid (w_hex)
    );

    assign w_take  = ioctl_wr & ioctl_download & enable;
    assign w_colon = (ioctl_dout == 8'h3A);
    assign w_dl    = ioctl_download & enable;
    assign w_start = w_dl & ~r_dl_prev;
    assign w_byte  = {r_hi, w_nib};
    assign w_sum   = r_sum + w_byte;
    assign w_ea    = r_base + {16'h0000, r_ofs};
    assign w_last  = (r_cnt == r_len - 8'd1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        if (!ioctl_download) begin
            w_state_n = ST_IDLE;
        end else if (w_take) begin
            if (w_colon) begin
                w_state_n = ST_LEN;
            end else if (r_state != ST_IDLE) begin
                if (!w_hex) begin
                    w_state_n = ST_IDLE;
                end else if (r_nib) begin
                    case (r_state)
                        ST_LEN:  w_state_n = ST_ADDR;
                        ST_ADDR: w_state_n = r_cnt[0] ? ST_TYPE : ST_ADDR;
                        ST_TYPE: w_state_n = (r_len != 8'd0) ? ST_DATA : ST_CSUM;
                        ST_DATA: w_state_n = w_last ? ST_CSUM : ST_DATA;
                        ST_CSUM: w_state_n = ST_IDLE;
                        default: w_state_n = ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_nib       <= 1'b0;
            r_hi        <= 4'h0;
            r_len       <= 8'h00;
            r_cnt       <= 8'h00;
            r_ofs       <= 16'h0000;
            r_type      <= 8'h00;
            r_sum       <= 8'h00;
            r_base      <= 32'h0;
            r_ext       <= 16'h0000;
            r_dl_prev   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= 8'h00;
            r_done      <= 1'b0;
            r_err_csum  <= 1'b0;
            r_err_char  <= 1'b0;
            r_err_range <= 1'b0;
            r_rec_cnt   <= 16'h0000;
        end else begin
            r_mem_wr  <= 1'b0;
            r_dl_prev <= w_dl;
            if (w_start) begin
                r_done      <= 1'b0;
                r_err_csum  <= 1'b0;
                r_err_char  <= 1'b0;
                r_err_range <= 1'b0;
                r_rec_cnt   <= 16'h0000;
                r_base      <= 32'h0;
            end
            if (!ioctl_download) begin
                r_nib <= 1'b0;
            end else if (w_take) begin
                if (w_colon) begin
                    // A colon always starts a fresh record; mid-record it is also an error
                    if (r_state != ST_IDLE) r_err_char <= 1'b1;
                    r_sum <= 8'h00;
                    r_nib <= 1'b0;
                end else if (r_state != ST_IDLE) begin
                    if (!w_hex) begin
                        r_err_char <= 1'b1;
                        r_nib      <= 1'b0;
                    end else if (!r_nib) begin
                        r_hi  <= w_nib;
                        r_nib <= 1'b1;
                    end else begin
                        r_nib <= 1'b0;
                        r_sum <= w_sum;
                        case (r_state)
                            ST_LEN: begin
                                r_len <= w_byte;
                                r_cnt <= 8'h00;
                            end
                            ST_ADDR: begin
                                if (!r_cnt[0]) r_ofs[15:8] <= w_byte;
                                else           r_ofs[7:0]  <= w_byte;
                                r_cnt <= r_cnt + 8'd1;
                            end
                            ST_TYPE: begin
                                r_type <= w_byte;
                                r_cnt  <= 8'h00;
                                r_ext  <= 16'h0000;
                            end
                            ST_DATA: begin
                                r_cnt <= r_cnt + 8'd1;
                                r_ext <= {r_ext[7:0], w_byte};
                                r_ofs <= r_ofs + 16'd1;
                                if (r_type == REC_DATA && !r_done) begin
                                    if (w_ea[31:ADDR_W] != '0) begin
                                        r_err_range <= 1'b1;
                                    end else begin
                                        r_mem_wr   <= 1'b1;
                                        r_mem_addr <= w_ea[ADDR_W-1:0];
                                        r_mem_data <= w_byte;
                                    end
                                end
                            end
                            ST_CSUM: begin
                                if (r_rec_cnt != 16'hFFFF) r_rec_cnt <= r_rec_cnt + 16'd1;
                                if (CHECK_CSUM && w_sum != 8'h00) r_err_csum <= 1'b1;
                                if (w_sum == 8'h00 && r_type == REC_EOF) r_done <= 1'b1;
                                // Base moves even on a bad checksum; the error flag reports it
                                if (EXT_ADDR) begin
                                    if (r_type == REC_ESA) r_base <= {12'h000, r_ext, 4'h0};
                                    if (r_type == REC_ELA) r_base <= {r_ext, 16'h0000};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign done      = r_done;
    assign err_csum  = r_err_csum;
    assign err_char  = r_err_char;
    assign err_range = r_err_range;
    assign rec_cnt   = r_rec_cnt;

endmodule

// File: tb/tb_ihex_loader.sv
// Bench for ihex_loader: directed and random HEX records checked against a record-level model.
module tb_ihex_loader;

    localparam int AW = 17;

    logic          clk_sys        = 1'b0;
    logic          reset_n        = 1'b0;
    logic          enable         = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr       = 1'b0;
    logic [7:0]    ioctl_dout     = 8'h00;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          done;
    logic          err_csum;
    logic          err_char;
    logic          err_range;
    logic [15:0]   rec_cnt;

    ihex_loader #(.ADDR_W(AW), .EXT_ADDR(1'b1), .CHECK_CSUM(1'b1)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .enable         (enable),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .done           (done),
        .err_csum       (err_csum),
        .err_char       (err_char),
        .err_range      (err_range),
        .rec_cnt        (rec_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int n_run  = 0;
    int n_fail = 0;

    logic [AW+7:0] got_q[$];
    logic [AW+7:0] exp_q[$];
    logic [7:0]    dq[$];

    logic [31:0] m_base = 32'h0;
    bit          m_done = 1'b0;
    bit          m_ec   = 1'b0;
    bit          m_ech  = 1'b0;
    bit          m_er   = 1'b0;
    int          m_rc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: a write must land in the cycle after a consumed strobe
    always @(posedge clk_sys) begin : mon
        bit s;
        s = ioctl_wr && ioctl_download && enable;
        #1;
        if (mem_wr) begin
            got_q.push_back({mem_addr, mem_data});
            chk("wr_timing", {31'h0, s}, 32'h1);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] hexc(input logic [3:0] n, input bit lc);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (lc ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    endfunction

    task automatic put(input logic [7:0] c, input int gap);
        ioctl_wr   = 1'b1;
        ioctl_dout = c;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (gap) @(negedge clk_sys);
    endtask

    task automatic put_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) put(s[i], gap);
    endtask

    task automatic crlf(input int gap);
        put(8'h0D, gap);
        put(8'h0A, gap);
    endtask

    task automatic put_byte(input logic [7:0] b, input bit lc, input int mg);
        put(hexc(b[7:4], lc), $urandom_range(mg));
        put(hexc(b[3:0], lc), $urandom_range(mg));
    endtask

    // Sends a record built from dq and advances the model by the record's meaning
    task automatic send_rec(input logic [7:0] typ, input logic [15:0] ofs,
                            input bit bad, input bit lc, input int mg);
        logic [7:0]  sum;
        logic [7:0]  cs;
        logic [15:0] val;
        logic [15:0] o;
        logic [31:0] ea;
        sum = 8'(dq.size()) + ofs[15:8] + ofs[7:0] + typ;
        foreach (dq[i]) sum += dq[i];
        cs = 8'h00 - sum;
        if (bad) cs = cs ^ 8'h5A;
        put(8'h3A, $urandom_range(mg));
        put_byte(8'(dq.size()), lc, mg);
        put_byte(ofs[15:8], lc, mg);
        put_byte(ofs[7:0], lc, mg);
        put_byte(typ, lc, mg);
        foreach (dq[i]) put_byte(dq[i], lc, mg);
        put_byte(cs, lc, mg);
        val = 16'h0;
        foreach (dq[i]) begin
            o  = ofs + 16'(i);
            ea = m_base + {16'h0, o};
            if (typ == 8'h00 && !m_done) begin
                if (ea >= (32'h1 << AW)) m_er = 1'b1;
                else exp_q.push_back({ea[AW-1:0], dq[i]});
            end
            val = {val[7:0], dq[i]};
        end
        if (m_rc < 65535) m_rc++;
        if (bad) m_ec = 1'b1;
        else if (typ == 8'h01) m_done = 1'b1;
        if (typ == 8'h02) m_base = {12'h0, val, 4'h0};
        if (typ == 8'h04) m_base = {val, 16'h0};
    endtask

    task automatic check_all(input string tag);
        int n;
        repeat (3) @(negedge clk_sys);
        chk({tag, ".nwr"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, ".wr"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        chk({tag, ".done"},  {31'h0, done},      {31'h0, m_done});
        chk({tag, ".ecsum"}, {31'h0, err_csum},  {31'h0, m_ec});
        chk({tag, ".echar"}, {31'h0, err_char},  {31'h0, m_ech});
        chk({tag, ".erng"},  {31'h0, err_range}, {31'h0, m_er});
        chk({tag, ".rcnt"},  {16'h0, rec_cnt},   32'(m_rc));
    endtask

    task automatic model_clear();
        m_base = 32'h0;
        m_done = 1'b0;
        m_ec   = 1'b0;
        m_ech  = 1'b0;
        m_er   = 1'b0;
        m_rc   = 0;
    endtask

    initial begin
        int r;
        bit lc;
        repeat (3) @(negedge clk_sys);
        chk("rst.mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("rst.addr",   32'(mem_addr), 32'h0);
        chk("rst.data",   {24'h0, mem_data}, 32'h0);
        check_all("rst");
        reset_n = 1'b1;
        @(negedge clk_sys);
        enable         = 1'b1;
        ioctl_download = 1'b1;
        @(negedge clk_sys);

        // Plain data record
        put_str(":0400000001020304F2", 1);
        crlf(0);
        for (int i = 0; i < 4; i++) exp_q.push_back({17'(i), 8'(i + 1)});
        m_rc++;
        check_all("t_data");

        // Extended linear address into the upper bank
        dq = '{8'h00, 8'h01}; send_rec(8'h04, 16'h0000, 1'b0, 1'b0, 1);
        dq = '{8'hAA};        send_rec(8'h00, 16'h0000, 1'b0, 1'b0, 1);
        check_all("t_ela");

        // Out-of-range base suppresses writes
        dq = '{8'h00, 8'h02}; send_rec(8'h04, 16'h0000, 1'b0, 1'b0, 0);
        dq = '{8'h77};        send_rec(8'h00, 16'h1234, 1'b0, 1'b0, 0);
        check_all("t_range");

        // Extended segment address
        dq = '{8'h10, 8'h00}; send_rec(8'h02, 16'h0000, 1'b0, 1'b0, 1);
        dq = '{8'h55};        send_rec(8'h00, 16'h0010, 1'b0, 1'b0, 1);
        check_all("t_esa");

        // Bad checksum still writes
        dq = '{8'h00, 8'h00}; send_rec(8'h04, 16'h0000, 1'b0, 1'b0, 0);
        put_str(":0100000011EF", 0);
        crlf(1);
        exp_q.push_back({17'h0, 8'h11});
        m_ec = 1'b1;
        m_rc++;
        check_all("t_csum");

        // Lowercase, back-to-back strobes
        put_str(":01000000ab54", 0);
        crlf(0);
        exp_q.push_back({17'h0, 8'hAB});
        m_rc++;
        check_all("t_lower");

        // Illegal character, then recovery
        put_str(":01G0", 1);
        crlf(1);
        m_ech = 1'b1;
        check_all("t_badch");
        dq = '{8'h5A}; send_rec(8'h00, 16'h0042, 1'b0, 1'b0, 0);
        check_all("t_recover");

        // Randomised record mix
        for (int k = 0; k < 25; k++) begin
            r  = $urandom_range(9);
            lc = 1'($urandom_range(1));
            dq.delete();
            if (r <= 5) begin
                for (int j = 0; j < int'($urandom_range(6, 1)); j++) dq.push_back(8'($urandom));
                send_rec(8'h00, 16'($urandom), ($urandom_range(7) == 0), lc, 2);
            end else if (r == 6 || r == 7) begin
                dq.push_back(8'h00);
                dq.push_back(8'($urandom_range(2)));
                send_rec(8'h04, 16'($urandom), ($urandom_range(7) == 0), lc, 2);
            end else if (r == 8) begin
                dq.push_back(8'($urandom_range(8'h20)));
                dq.push_back(8'($urandom));
                send_rec(8'h02, 16'($urandom), ($urandom_range(7) == 0), lc, 2);
            end else begin
                for (int j = 0; j < int'($urandom_range(3)); j++) dq.push_back(8'($urandom));
                send_rec(8'h03, 16'($urandom), 1'b0, lc, 2);
            end
            if ($urandom_range(1) == 1) crlf(0);
            check_all("t_rand");
        end

        // End of file
        dq.delete();
        send_rec(8'h01, 16'h0000, 1'b0, 1'b0, 0);
        check_all("t_eof");

        // Abort mid-record, status holds, restart clears
        put_str(":0100", 0);
        ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_all("t_abort");
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        model_clear();
        check_all("t_restart");
        put_str("00AA55", 0);
        crlf(0);
        dq = '{8'h99}; send_rec(8'h00, 16'h0005, 1'b0, 1'b0, 1);
        check_all("t_first");

        // Colon inside a record restarts it
        put_str(":01", 0);
        dq = '{8'h3C}; send_rec(8'h00, 16'h0009, 1'b0, 1'b0, 0);
        m_ech = 1'b1;
        check_all("t_colon");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
